// File: rtl/add8u_share_arb.sv
// add8u_share_arb: round-robin arbiter feeding one shared external 8-bit adder
// through a two-stage pipeline (operand register S1, result register S2).
// Also forms the exact sum internally, selects exact or external results
// per exact_mode, and keeps saturating operation / error counters.
module add8u_share_arb #(
    parameter int NREQ = 4,
    parameter int CNTW = 16,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*8-1:0]   req_a,
    input  logic [NREQ*8-1:0]   req_b,
    output logic [7:0]          add_a,
    output logic [7:0]          add_b,
    input  logic [8:0]          add_o,
    input  logic                exact_mode,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [8:0]          res_sum,
    output logic [IDW-1:0]      res_id,
    output logic [CNTW-1:0]     op_count,
    output logic [CNTW-1:0]     err_count,
    input  logic                clr_stats
);

    // S1 operand stage and round-robin pointer
    logic            op_v;
    logic [7:0]      op_a;
    logic [7:0]      op_b;
    logic [IDW-1:0]  op_id;
    logic [IDW-1:0]  ptr;

    // Pipeline handshake terms
    logic            s2_free;
    logic            s1_adv;
    logic            s1_free;
    logic            accept;

    // Arbitration results
    logic            grant_hit;
    logic [IDW-1:0]  grant_id;
    logic [NREQ-1:0] grant;
    logic [7:0]      grant_a;
    logic [7:0]      grant_b;
    logic [IDW-1:0]  ptr_next;

    logic [8:0]      exact_sum;
    logic            add_err;

    assign add_a     = op_a;
    assign add_b     = op_b;
    assign exact_sum = {1'b0, op_a} + {1'b0, op_b};
    assign add_err   = (add_o != exact_sum);

    assign s2_free = !res_valid || res_ready;
    assign s1_adv  = op_v && s2_free;
    assign s1_free = !op_v || s1_adv;

    // The grant vector only ever has a valid requester's bit set, so any
    // ready bit implies an accept.
    assign req_ready = grant & {NREQ{s1_free && !rst}};
    assign accept    = |req_ready;

    assign ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

    // Rotating-priority search: first valid requester at or after ptr, wrapping
    always_comb begin
        logic [IDW-1:0] idx;
        idx       = '0;
        grant     = '0;
        grant_hit = 1'b0;
        grant_id  = '0;
        grant_a   = '0;
        grant_b   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(ptr) + k) % NREQ);
            if (!grant_hit && req_valid[idx]) begin
                grant_hit   = 1'b1;
                grant_id    = idx;
                grant[idx]  = 1'b1;
                grant_a     = req_a[{idx, 3'b000} +: 8];
                grant_b     = req_b[{idx, 3'b000} +: 8];
            end
        end
    end

    // S1: load on accept, drain on advance; a simultaneous accept keeps it full
    always_ff @(posedge clk) begin
        if (rst) begin
            op_v  <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            op_id <= '0;
            ptr   <= '0;
        end else begin
            if (accept) begin
                op_v  <= 1'b1;
                op_a  <= grant_a;
                op_b  <= grant_b;
                op_id <= grant_id;
                ptr   <= ptr_next;
            end else if (s1_adv) begin
                op_v  <= 1'b0;
            end
        end
    end

    // S2: capture exact or external sum when S1 advances, hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_id    <= '0;
        end else if (s1_adv) begin
            res_valid <= 1'b1;
            res_sum   <= exact_mode ? exact_sum : add_o;
            res_id    <= op_id;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // Saturating statistics; a clear in the same cycle as an advance wins
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count  <= '0;
            err_count <= '0;
        end else if (clr_stats) begin
            op_count  <= '0;
            err_count <= '0;
        end else if (s1_adv) begin
            if (op_count != '1) begin
                op_count <= op_count + CNTW'(1);
            end
            if (add_err && (err_count != '1)) begin
                err_count <= err_count + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_add8u_share_arb.sv
// Testbench for add8u_share_arb: transaction-queue reference model with
// randomized operands and traffic, plus directed scenarios.
module tb_add8u_share_arb;

    localparam int NREQ = 4;
    localparam int CNTW = 4;
    localparam int IDW  = 2;
    localparam int CMAX = (1 << CNTW) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*8-1:0]   req_a;
    logic [NREQ*8-1:0]   req_b;
    logic [7:0]          add_a;
    logic [7:0]          add_b;
    logic [8:0]          add_o;
    logic                exact_mode;
    logic                res_valid;
    logic                res_ready;
    logic [8:0]          res_sum;
    logic [IDW-1:0]      res_id;
    logic [CNTW-1:0]     op_count;
    logic [CNTW-1:0]     err_count;
    logic                clr_stats;
    logic                approx_en;

    always #5 clk = ~clk;

    // External adder: exact, or exact-15 when approximation is enabled
    assign add_o = approx_en ? ({1'b0, add_a} + {1'b0, add_b} - 9'd15)
                             : ({1'b0, add_a} + {1'b0, add_b});

    add8u_share_arb #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_a(add_a), .add_b(add_b), .add_o(add_o),
        .exact_mode(exact_mode),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_id(res_id),
        .op_count(op_count), .err_count(err_count),
        .clr_stats(clr_stats)
    );

    // Reference model: in-flight transactions oldest first. An entry marked
    // done has its result fixed and is the visible result; an undone entry
    // is waiting for its add.
    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        bit         done;
        logic [8:0] sum;
    } txn_t;

    txn_t            pipe[$];
    int              m_ptr;
    int              m_opc;
    int              m_errc;
    bit              m_s2occ, m_s1has, m_s1adv, m_s1free;
    int              m_gid;
    logic [NREQ-1:0] exp_ready;
    logic [8:0]      exp_sum;
    int              exp_id;

    int total = 0;
    int bad   = 0;

    function automatic void predict();
        int j;
        m_s2occ  = (pipe.size() > 0) && pipe[0].done;
        m_s1has  = (pipe.size() > 0) && !pipe[pipe.size()-1].done;
        m_s1adv  = m_s1has && (!m_s2occ || res_ready);
        m_s1free = !m_s1has || m_s1adv;
        m_gid = -1;
        for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (m_gid < 0 && req_valid[j]) m_gid = j;
        end
        exp_ready = '0;
        if (!rst && m_gid >= 0 && m_s1free) exp_ready[m_gid] = 1'b1;
        exp_sum = m_s2occ ? pipe[0].sum : 9'd0;
        exp_id  = m_s2occ ? pipe[0].id : 0;
    endfunction

    function automatic void commit();
        int   last;
        int   e;
        int   ao;
        txn_t t;
        if (rst) begin
            pipe.delete();
            m_ptr = 0; m_opc = 0; m_errc = 0;
            return;
        end
        if (m_s2occ && res_ready) void'(pipe.pop_front());
        if (m_s1adv) begin
            last = pipe.size() - 1;
            t  = pipe[last];
            e  = int'(t.a) + int'(t.b);
            ao = approx_en ? ((e - 15) & 511) : e;
            t.sum  = exact_mode ? 9'(e) : 9'(ao);
            t.done = 1'b1;
            pipe[last] = t;
            if (m_opc < CMAX) m_opc++;
            if (ao != e && m_errc < CMAX) m_errc++;
        end
        if (clr_stats) begin
            m_opc = 0; m_errc = 0;
        end
        if (exp_ready != '0) begin
            t.id   = m_gid;
            t.a    = req_a[8*m_gid +: 8];
            t.b    = req_b[8*m_gid +: 8];
            t.done = 1'b0;
            t.sum  = '0;
            pipe.push_back(t);
            m_ptr = (m_gid + 1) % NREQ;
        end
    endfunction

    task automatic settle();
        #1;
        predict();
    endtask

    task automatic tick();
        commit();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[8*i +: 8] = 8'($urandom);
            req_b[8*i +: 8] = 8'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; res_ready = 1'b1; clr_stats = 1'b0;
        exact_mode = 1'b0; approx_en = 1'b0;
        repeat (2) begin
            settle();
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; res_ready = 1'b1; clr_stats = 1'b0;
        exact_mode = 1'b0; approx_en = 1'b0;
        rand_ops();
        settle();
        total++;
        if (req_ready !== '0) begin
            bad++; $display("FAIL reset_ready_comb: got %b want 0", req_ready);
        end
        tick();
        repeat (2) begin
            rand_ops();
            settle();
            total++;
            if (req_ready !== '0 || res_valid !== 1'b0) begin
                bad++; $display("FAIL reset_hs: ready=%b valid=%b want 0/0", req_ready, res_valid);
            end
            total++;
            if (res_sum !== 9'd0 || res_id !== '0 || add_a !== 8'd0 || add_b !== 8'd0) begin
                bad++; $display("FAIL reset_regs: sum=%0d id=%0d a=%0d b=%0d want 0", res_sum, res_id, add_a, add_b);
            end
            total++;
            if (op_count !== '0 || err_count !== '0) begin
                bad++; $display("FAIL reset_counts: op=%0d err=%0d want 0/0", op_count, err_count);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int n;
        rand_ops();
        req_a[23:16] = 8'd200;
        req_b[23:16] = 8'd100;
        req_valid = 4'b0100;
        settle();
        total++;
        if (req_ready !== 4'b0100 || req_ready !== exp_ready) begin
            bad++; $display("FAIL single_ready: got %b want %b", req_ready, exp_ready);
        end
        tick();
        req_valid = '0;
        for (n = 0; n < 4; n++) begin
            settle();
            total++;
            if (res_valid !== m_s2occ) begin
                bad++; $display("FAIL single_timing: res_valid=%b want %b", res_valid, m_s2occ);
            end
            if (res_valid) break;
            tick();
        end
        total++;
        if (n == 4) begin
            bad++; $display("FAIL single_timeout: no result within %0d cycles", n);
        end else if (res_sum !== 9'd300 || res_id !== 2'd2) begin
            bad++; $display("FAIL single_result: sum=%0d id=%0d want 300/2", res_sum, res_id);
        end
        total++;
        if (op_count !== 4'd1 || err_count !== 4'd0) begin
            bad++; $display("FAIL single_counts: op=%0d err=%0d want 1/0", op_count, err_count);
        end
        tick();
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] want;
        do_reset();
        req_valid = '1;
        for (int k = 0; k < 10; k++) begin
            rand_ops();
            settle();
            want = NREQ'(1) << (k % NREQ);
            total++;
            if (req_ready !== want || req_ready !== exp_ready) begin
                bad++; $display("FAIL fair_grant[%0d]: got %b want %b", k, req_ready, want);
            end
            if (k >= 2) begin
                total++;
                if (res_valid !== 1'b1 || res_id !== IDW'((k - 2) % NREQ) || res_sum !== exp_sum) begin
                    bad++; $display("FAIL fair_result[%0d]: v=%b id=%0d sum=%0d want 1/%0d/%0d",
                                    k, res_valid, res_id, res_sum, (k - 2) % NREQ, exp_sum);
                end
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [NREQ-1:0] want;
        do_reset();
        res_ready = 1'b0;
        req_valid = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            if (k < 2) rand_ops();
            settle();
            want = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0010 : 4'b0000;
            total++;
            if (req_ready !== want || req_ready !== exp_ready) begin
                bad++; $display("FAIL bp_ready[%0d]: got %b want %b", k, req_ready, want);
            end
            if (k >= 2) begin
                total++;
                if (res_valid !== 1'b1 || res_id !== 2'd0 || res_sum !== exp_sum) begin
                    bad++; $display("FAIL bp_hold[%0d]: v=%b id=%0d sum=%0d want 1/0/%0d",
                                    k, res_valid, res_id, res_sum, exp_sum);
                end
            end
            tick();
        end
        req_valid = '0;
        res_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            settle();
            total++;
            if (res_valid !== 1'b1 || res_id !== IDW'(k) || res_sum !== exp_sum) begin
                bad++; $display("FAIL bp_release[%0d]: v=%b id=%0d sum=%0d want 1/%0d/%0d",
                                k, res_valid, res_id, res_sum, k, exp_sum);
            end
            tick();
        end
        settle();
        total++;
        if (res_valid !== 1'b0) begin
            bad++; $display("FAIL bp_drained: res_valid=%b want 0", res_valid);
        end
        tick();
    endtask

    task automatic test_approx();
        do_reset();
        approx_en = 1'b1;
        for (int m = 0; m < 2; m++) begin
            exact_mode = (m == 1);
            rand_ops();
            req_a[7:0] = 8'd60;
            req_b[7:0] = 8'd3;
            req_valid  = 4'b0001;
            settle();
            tick();
            req_valid = '0;
            settle();
            tick();
            settle();
            total++;
            if (res_valid !== 1'b1 || res_sum !== (m == 1 ? 9'd63 : 9'd48) || res_sum !== exp_sum) begin
                bad++; $display("FAIL approx_sum[mode=%0d]: v=%b sum=%0d want 1/%0d",
                                m, res_valid, res_sum, (m == 1) ? 63 : 48);
            end
            total++;
            if (err_count !== CNTW'(m + 1) || op_count !== CNTW'(m + 1)) begin
                bad++; $display("FAIL approx_err[mode=%0d]: err=%0d op=%0d want %0d/%0d",
                                m, err_count, op_count, m + 1, m + 1);
            end
            tick();
        end
        approx_en = 1'b0;
        exact_mode = 1'b0;
    endtask

    task automatic test_counters();
        do_reset();
        req_valid = 4'b0001;
        for (int k = 0; k < 22; k++) begin
            rand_ops();
            settle();
            total++;
            if (op_count !== CNTW'(m_opc)) begin
                bad++; $display("FAIL cnt_track[%0d]: op=%0d want %0d", k, op_count, m_opc);
            end
            tick();
        end
        settle();
        total++;
        if (op_count !== 4'd15) begin
            bad++; $display("FAIL cnt_saturate: op=%0d want 15", op_count);
        end
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        settle();
        total++;
        if (op_count !== 4'd0 || err_count !== 4'd0) begin
            bad++; $display("FAIL cnt_clear_wins: op=%0d err=%0d want 0/0", op_count, err_count);
        end
        tick();
        settle();
        total++;
        if (op_count !== 4'd1) begin
            bad++; $display("FAIL cnt_after_clear: op=%0d want 1", op_count);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            req_valid  = NREQ'($urandom);
            res_ready  = ($urandom_range(3) != 0);
            exact_mode = 1'($urandom);
            approx_en  = ($urandom_range(3) == 0);
            clr_stats  = ($urandom_range(40) == 0);
            rand_ops();
            settle();
            total++;
            if (req_ready !== exp_ready) begin
                bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", k, req_ready, exp_ready);
            end
            total++;
            if (res_valid !== m_s2occ || (m_s2occ && (res_sum !== exp_sum || res_id !== IDW'(exp_id)))) begin
                bad++; $display("FAIL rnd_result[%0d]: v=%b sum=%0d id=%0d want %b/%0d/%0d",
                                k, res_valid, res_sum, res_id, m_s2occ, exp_sum, exp_id);
            end
            total++;
            if (op_count !== CNTW'(m_opc) || err_count !== CNTW'(m_errc)) begin
                bad++; $display("FAIL rnd_counts[%0d]: op=%0d err=%0d want %0d/%0d",
                                k, op_count, err_count, m_opc, m_errc);
            end
            if (m_s1has) begin
                total++;
                if (add_a !== pipe[pipe.size()-1].a || add_b !== pipe[pipe.size()-1].b) begin
                    bad++; $display("FAIL rnd_operands[%0d]: a=%0d b=%0d want %0d/%0d", k, add_a, add_b,
                                    pipe[pipe.size()-1].a, pipe[pipe.size()-1].b);
                end
            end
            tick();
        end
        clr_stats = 1'b0;
        approx_en = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        res_ready = 1'b0;
        req_valid = '1;
        repeat (3) begin
            rand_ops();
            settle();
            tick();
        end
        settle();
        total++;
        if (!(m_s2occ && m_s1has) || res_valid !== 1'b1) begin
            bad++; $display("FAIL mid_full: res_valid=%b want 1 with both stages full", res_valid);
        end
        rst = 1'b1;
        req_valid = 4'b1010;
        settle();
        total++;
        if (req_ready !== '0) begin
            bad++; $display("FAIL mid_ready_in_rst: got %b want 0", req_ready);
        end
        tick();
        settle();
        total++;
        if (res_valid !== 1'b0 || req_ready !== '0 || op_count !== '0) begin
            bad++; $display("FAIL mid_cleared: v=%b ready=%b op=%0d want 0/0/0", res_valid, req_ready, op_count);
        end
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        settle();
        total++;
        if (req_ready !== 4'b0010 || req_ready !== exp_ready) begin
            bad++; $display("FAIL mid_first_grant: got %b want 0010", req_ready);
        end
        tick();
        req_valid = '0;
        settle();
        tick();
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; res_ready = 1'b1; clr_stats = 1'b0;
        exact_mode = 1'b0; approx_en = 1'b0; req_a = '0; req_b = '0;
        pipe.delete(); m_ptr = 0; m_opc = 0; m_errc = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_approx();
        test_counters();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
